text_memory_arbiter: RTL and testbench

Shares the single-port, synchronous-read text memory between the core instruction-fetch port and a debug/loader port. The loader port can read and write program words. The arbiter sequences every access as a request/accept/response transaction with one-cycle memory latency, and it range- and alignment-checks addresses before touching the memory. It sits between the core fetch stage, the debug/loader unit, and the text memory macro (14-bit word address, registered address input, unregistered q output).

---
 rtl/text_memory_arbiter.sv | 72 +++++++
 tb/tb_text_memory_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/text_memory_arbiter.sv
// text_memory_arbiter: round-robin fetch/debug access to the single-port text memory.
module text_memory_arbiter #(
  parameter logic [31:0] TEXT_BEGIN = 32'h0040_0000,
  parameter logic [31:0] TEXT_END   = 32'h0040_FFFC,
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] FAULT_WORD = 32'h0000_0001
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_address,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_data,
  output logic                  fetch_fault,
  input  logic                  dbg_req,
  input  logic                  dbg_write,
  input  logic [31:0]           dbg_address,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_ready,
  output logic                  dbg_valid,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  output logic [31:0]           mem_data,
  input  logic [31:0]           mem_q
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic last_dbg, resp_dbg, resp_fault, resp_write;
  logic idle, acc_f, acc_d, f_fault, d_fault;
  function automatic logic bad(input logic [31:0] a);
    return a < TEXT_BEGIN || a > TEXT_END || a[1:0] != 2'b00;
  endfunction
  always_comb begin
    idle        = reset && state == IDLE;
    fetch_ready = idle && (!dbg_req || (fetch_req && last_dbg));
    dbg_ready   = idle && (!fetch_req || (dbg_req && !last_dbg));
    acc_f       = fetch_req && fetch_ready;
    acc_d       = dbg_req && dbg_ready;
    f_fault     = bad(fetch_address);
    d_fault     = bad(dbg_address);
    mem_address = acc_d ? dbg_address[ADDR_WIDTH+1:2] : acc_f ? fetch_address[ADDR_WIDTH+1:2] : '0;
    mem_wren    = acc_d && dbg_write && !d_fault;
    mem_data    = mem_wren ? dbg_wdata : '0;
    fetch_valid = reset && state == RESP && !resp_dbg;
    fetch_fault = fetch_valid && resp_fault;
    fetch_data  = !fetch_valid ? '0 : resp_fault ? FAULT_WORD : mem_q;
    dbg_valid   = reset && state == RESP && resp_dbg;
    dbg_fault   = dbg_valid && resp_fault;
    dbg_rdata   = (!dbg_valid || resp_write) ? '0 : resp_fault ? FAULT_WORD : mem_q;
  end
  // last_dbg resets to debug so the first collision goes to fetch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_dbg   <= 1'b1;
      resp_dbg   <= 1'b0;
      resp_fault <= 1'b0;
      resp_write <= 1'b0;
    end else if (state == RESP) begin
      state <= IDLE;
    end else if (acc_f || acc_d) begin
      state      <= RESP;
      last_dbg   <= acc_d;
      resp_dbg   <= acc_d;
      resp_fault <= acc_d ? d_fault : f_fault;
      resp_write <= acc_d && dbg_write;
    end
  end
endmodule

// File: tb/tb_text_memory_arbiter.sv
// tb_text_memory_arbiter: directed plus random checks against a transaction-level model.
module tb_text_memory_arbiter;
  localparam logic [31:0] TB_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TB_END   = 32'h0040_FFFC;
  localparam logic [31:0] TB_FW    = 32'h0000_0001;
  logic clock, reset;
  logic fetch_req, fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_address, fetch_data;
  logic dbg_req, dbg_write, dbg_ready, dbg_valid, dbg_fault;
  logic [31:0] dbg_address, dbg_wdata, dbg_rdata;
  logic [13:0] mem_address, addr_r;
  logic mem_wren;
  logic [31:0] mem_data, mem_q;
  logic [31:0] tmem [0:16383];
  bit tw [0:16383];
  logic [31:0] rmem [int];
  int n_cmp = 0, n_err = 0;
  bit m_resp, m_dbg, m_last_dbg, m_fault;
  logic [31:0] m_data;
  logic af, ad;
  bit f_on, d_on, d_w;
  logic [31:0] f_a, d_a, d_d;

  text_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata), .dbg_fault(dbg_fault),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h13;
  endfunction

  // text memory macro: registered address, unregistered q
  always @(posedge clock) begin
    if (mem_wren) begin
      tmem[mem_address] <= mem_data;
      tw[mem_address] <= 1'b1;
    end
    addr_r <= mem_address;
  end
  assign mem_q = tw[addr_r] ? tmem[addr_r] : init_word(int'(addr_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_text(input logic [31:0] a);
    return a >= TB_BEGIN && a <= TB_END && a % 4 == 0;
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    return rmem.exists(idx) ? rmem[idx] : init_word(idx);
  endfunction

  task automatic cycle(input bit fr, input logic [31:0] fa, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd,
                       output logic acc_f, output logic acc_d);
    bit efr, edr, efv, edv, flt;
    int idx;
    logic [31:0] a;
    @(negedge clock);
    fetch_req = fr; fetch_address = fa;
    dbg_req = dr; dbg_write = dw; dbg_address = da; dbg_wdata = dd;
    #1;
    efv = m_resp && !m_dbg;
    edv = m_resp && m_dbg;
    if (m_resp) begin efr = 0; edr = 0; end
    else if (fr && dr) begin efr = m_last_dbg; edr = !m_last_dbg; end
    else if (fr) begin efr = 1; edr = 0; end
    else if (dr) begin efr = 0; edr = 1; end
    else begin efr = 1; edr = 1; end
    acc_f = fr && efr;
    acc_d = dr && edr;
    a = acc_d ? da : fa;
    flt = !in_text(a);
    idx = int'((a - TB_BEGIN) / 4) & 16'h3FFF;
    chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, efr});
    chk("dbg_ready", {31'b0, dbg_ready}, {31'b0, edr});
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, efv});
    chk("dbg_valid", {31'b0, dbg_valid}, {31'b0, edv});
    chk("fetch_data", fetch_data, efv ? m_data : 32'h0);
    chk("dbg_rdata", dbg_rdata, edv ? m_data : 32'h0);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, efv && m_fault});
    chk("dbg_fault", {31'b0, dbg_fault}, {31'b0, edv && m_fault});
    chk("mem_wren", {31'b0, mem_wren}, {31'b0, acc_d && dw && !flt});
    if (acc_f || acc_d) chk("mem_address", {18'b0, mem_address}, {18'b0, a[15:2]});
    if (acc_d && dw && !flt) chk("mem_data", mem_data, dd);
    if (m_resp) m_resp = 0;
    else if (acc_f || acc_d) begin
      m_resp = 1;
      m_dbg = acc_d;
      m_last_dbg = acc_d;
      m_fault = flt;
      m_data = (acc_d && dw) ? 32'h0 : flt ? TB_FW : ref_read(idx);
      if (acc_d && dw && !flt) rmem[idx] = dd;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return TB_BEGIN + 4 * $urandom_range(0, 16383);
      1: return TB_BEGIN + {$urandom_range(0, 16383), 2'(1 + $urandom_range(0, 2))};
      2: return TB_BEGIN - 4 * (1 + $urandom_range(0, 100));
      3: return TB_END + 4 * (1 + $urandom_range(0, 100));
      default: return TB_BEGIN + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  task automatic model_reset();
    m_resp = 0; m_dbg = 0; m_last_dbg = 1; m_fault = 0; m_data = 0;
  endtask

  initial begin
    model_reset();
    reset = 0;
    fetch_req = 1; fetch_address = TB_BEGIN;
    dbg_req = 1; dbg_write = 1; dbg_address = TB_BEGIN; dbg_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clock);
    chk("rst fetch_ready", {31'b0, fetch_ready}, 32'h0);
    chk("rst dbg_ready", {31'b0, dbg_ready}, 32'h0);
    chk("rst mem_wren", {31'b0, mem_wren}, 32'h0);
    chk("rst mem_address", {18'b0, mem_address}, 32'h0);
    chk("rst valids", {30'b0, fetch_valid, dbg_valid}, 32'h0);
    chk("rst data", fetch_data | dbg_rdata | mem_data, 32'h0);
    fetch_req = 0; dbg_req = 0;
    reset = 1;
    cycle(1, TB_BEGIN, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 1, 1, 32'h0040_0010, 32'hDEAD_BEEF, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    cycle(1, 32'h0040_0010, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    chk("readback", m_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) cycle(1, TB_BEGIN + 8, 1, 0, 32'h0040_0010, 0, af, ad);
    cycle(1, 32'h0041_0000, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    cycle(1, 32'h0040_0002, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 1, 1, 32'h003F_FFFC, 32'h1234_5678, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    cycle(1, TB_END, 0, 0, 0, 0, af, ad);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    cycle(1, 32'h0040_0004, 0, 0, 0, 0, af, ad);
    @(negedge clock);
    fetch_req = 0; dbg_req = 0;
    #1;
    chk("pre-abort fetch_valid", {31'b0, fetch_valid}, 32'h1);
    reset = 0;
    #1;
    chk("abort fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("abort fetch_data", fetch_data, 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1;
    cycle(1, TB_BEGIN + 12, 1, 0, TB_BEGIN + 16, 0, af, ad);
    chk("post-reset grant", {30'b0, af, ad}, 32'h2);
    cycle(0, 0, 0, 0, 0, 0, af, ad);
    f_on = 0; d_on = 0; d_w = 0; f_a = 0; d_a = 0; d_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!f_on && $urandom_range(0, 1) == 1) begin f_on = 1; f_a = rand_addr(); end
      if (!d_on && $urandom_range(0, 2) == 0) begin
        d_on = 1; d_a = rand_addr(); d_w = $urandom_range(0, 1) == 1; d_d = $urandom;
      end
      cycle(f_on, f_a, d_on, d_w, d_a, d_d, af, ad);
      if (af) f_on = 0;
      if (ad) d_on = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
